// File: rtl/multicycle_main_ctrl_if.sv
// Control bundle between the multicycle main FSM (master) and the shared datapath (slave).
// The master modport drives the control word and samples the status inputs.
interface multicycle_main_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       opcode;
   logic             funct3_0;
   logic             zero;
   logic             mem_ready;
   logic             mem_req;
   logic             adr_src;
   logic             mem_write;
   logic             ir_write;
   logic [1:0]       result_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             reg_write;
   logic             pc_write;
   logic             illegal;
   logic [CNT_W-1:0] instret;
   logic [3:0]       state_dbg;

   modport master (
      input  opcode, funct3_0, zero, mem_ready,
      output mem_req, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, reg_write, pc_write, illegal, instret, state_dbg
   );

   modport slave (
      output opcode, funct3_0, zero, mem_ready,
      input  mem_req, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, reg_write, pc_write, illegal, instret, state_dbg
   );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute/memory/
// writeback over the shared datapath, waits on memory, counts retirements, traps on bad opcodes.
module multicycle_main_ctrl #(
   parameter int CNT_W = 32,
   parameter int OP_W  = 7
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_main_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] instret_q;
   logic             illegal_q;
   logic             retire;
   logic [OP_W-1:0]  op;

   logic       c_mem_req, c_adr_src, c_mem_write, c_ir_write, c_reg_write, c_pc_write;
   logic [1:0] c_result_src, c_alu_src_a, c_alu_src_b, c_alu_op;

   assign op = bus.opcode;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         instret_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_n;
         if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (state_n == TRAP) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_n      = state_q;
      retire       = 1'b0;
      c_mem_req    = 1'b0;
      c_adr_src    = 1'b0;
      c_mem_write  = 1'b0;
      c_ir_write   = 1'b0;
      c_reg_write  = 1'b0;
      c_pc_write   = 1'b0;
      c_result_src = 2'b00;
      c_alu_src_a  = 2'b00;
      c_alu_src_b  = 2'b00;
      c_alu_op     = 2'b00;
      case (state_q)
         FETCH: begin
            // PC+4 is computed every fetch cycle; only the ready cycle commits it
            c_mem_req    = 1'b1;
            c_alu_src_b  = 2'b10;
            c_result_src = 2'b10;
            c_ir_write   = bus.mem_ready;
            c_pc_write   = bus.mem_ready;
            if (bus.mem_ready) state_n = DECODE;
         end
         DECODE: begin
            c_alu_src_a = 2'b01;
            c_alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_R:         state_n = EXECR;
               OP_I:         state_n = EXECI;
               OP_BR:        state_n = BRANCH;
               OP_JAL:       state_n = JAL;
               default:      state_n = TRAP;
            endcase
         end
         MEMADR: begin
            c_alu_src_a = 2'b10;
            c_alu_src_b = 2'b01;
            state_n     = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            c_mem_req = 1'b1;
            c_adr_src = 1'b1;
            if (bus.mem_ready) state_n = MEMWB;
         end
         MEMWB: begin
            c_result_src = 2'b01;
            c_reg_write  = 1'b1;
            state_n      = FETCH;
            retire       = 1'b1;
         end
         MEMWRITE: begin
            c_mem_req   = 1'b1;
            c_adr_src   = 1'b1;
            c_mem_write = 1'b1;
            if (bus.mem_ready) begin
               state_n = FETCH;
               retire  = 1'b1;
            end
         end
         EXECR: begin
            c_alu_src_a = 2'b10;
            c_alu_op    = 2'b10;
            state_n     = ALUWB;
         end
         EXECI: begin
            c_alu_src_a = 2'b10;
            c_alu_src_b = 2'b01;
            c_alu_op    = 2'b10;
            state_n     = ALUWB;
         end
         ALUWB: begin
            c_reg_write = 1'b1;
            state_n     = FETCH;
            retire      = 1'b1;
         end
         BRANCH: begin
            // instr[12] flips the sense of the zero flag: beq takes on zero, bne on non-zero
            c_alu_src_a = 2'b10;
            c_alu_op    = 2'b01;
            c_pc_write  = bus.zero ^ bus.funct3_0;
            state_n     = FETCH;
            retire      = 1'b1;
         end
         JAL: begin
            c_alu_src_a = 2'b01;
            c_alu_src_b = 2'b10;
            c_pc_write  = 1'b1;
            state_n     = ALUWB;
         end
         TRAP:    state_n = TRAP;
         default: state_n = FETCH;
      endcase
   end

   // Reset masks the control word combinationally so no strobe survives the reset edge
   assign bus.mem_req    = c_mem_req   & ~reset;
   assign bus.adr_src    = c_adr_src   & ~reset;
   assign bus.mem_write  = c_mem_write & ~reset;
   assign bus.ir_write   = c_ir_write  & ~reset;
   assign bus.reg_write  = c_reg_write & ~reset;
   assign bus.pc_write   = c_pc_write  & ~reset;
   assign bus.result_src = reset ? 2'b00 : c_result_src;
   assign bus.alu_src_a  = reset ? 2'b00 : c_alu_src_a;
   assign bus.alu_src_b  = reset ? 2'b00 : c_alu_src_b;
   assign bus.alu_op     = reset ? 2'b00 : c_alu_op;
   assign bus.illegal    = illegal_q;
   assign bus.instret    = instret_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed bench for multicycle_main_ctrl: instruction-level expectation queue, per-cycle compare
// on a 32-bit-counter instance and a 4-bit-counter instance driven in lockstep.
module tb_multicycle_main_ctrl;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b0000000;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, adr_src, mem_write, ir_write;
      logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
      logic       reg_write, pc_write, illegal;
   } ctl_t;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        f3, zr, rdy;
      ctl_t        e;
      logic [31:0] cnt;
   } cyc_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = '0;
   logic       f3 = 1'b0, zr = 1'b0, rdy = 1'b0;

   always #5 clk = ~clk;

   multicycle_main_ctrl_if #(.CNT_W(32)) b32 ();
   multicycle_main_ctrl_if #(.CNT_W(4))  b4 ();

   assign b32.opcode = op;   assign b4.opcode = op;
   assign b32.funct3_0 = f3; assign b4.funct3_0 = f3;
   assign b32.zero = zr;     assign b4.zero = zr;
   assign b32.mem_ready = rdy; assign b4.mem_ready = rdy;

   multicycle_main_ctrl #(.CNT_W(32), .OP_W(7)) dut (.clk(clk), .reset(reset), .bus(b32));
   multicycle_main_ctrl #(.CNT_W(4),  .OP_W(7)) dut4 (.clk(clk), .reset(reset), .bus(b4));

   ctl_t a32, a4;
   assign a32 = {b32.state_dbg, b32.mem_req, b32.adr_src, b32.mem_write, b32.ir_write,
                 b32.result_src, b32.alu_src_a, b32.alu_src_b, b32.alu_op,
                 b32.reg_write, b32.pc_write, b32.illegal};
   assign a4  = {b4.state_dbg, b4.mem_req, b4.adr_src, b4.mem_write, b4.ir_write,
                 b4.result_src, b4.alu_src_a, b4.alu_src_b, b4.alu_op,
                 b4.reg_write, b4.pc_write, b4.illegal};

   cyc_t        q[$];
   cyc_t        cur;
   bit          cur_v = 1'b0;
   int          cyc_i = 0;
   logic [31:0] m_cnt = '0;
   logic        m_ill = 1'b0;
   logic [6:0]  m_op = '0;
   logic        m_f3 = 1'b0;
   logic        noise = 1'b0;
   int          checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_i, act, exp);
      end
   endtask

   function automatic ctl_t blank(input logic [3:0] st);
      ctl_t c = '0;
      c.st = st;
      return c;
   endfunction

   task automatic push(input logic rs, input logic rd, input logic z, input ctl_t e);
      cyc_t c;
      c.rst = rs; c.op = m_op; c.f3 = m_f3; c.zr = z; c.rdy = rd;
      e.illegal = m_ill;
      c.e   = rs ? '0 : e;
      c.cnt = m_cnt;
      q.push_back(c);
   endtask

   // Steps where the controller must ignore mem_ready and zero get toggling junk on both
   task automatic push_n(input ctl_t e);
      push(1'b0, noise, ~noise, e);
      noise = ~noise;
   endtask

   task automatic do_reset(input int n);
      m_cnt = '0;
      m_ill = 1'b0;
      repeat (n) begin
         push(1'b1, noise, noise, '0);
         noise = ~noise;
      end
   endtask

   task automatic s_fetch(input int waits);
      ctl_t e;
      for (int i = 0; i <= waits; i++) begin
         e = blank(4'd0);
         e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
         e.ir_write = (i == waits); e.pc_write = (i == waits);
         push(1'b0, (i == waits), noise, e);
         noise = ~noise;
      end
   endtask

   task automatic s_aluwb();
      ctl_t e = blank(4'd8);
      e.reg_write = 1'b1;
      push_n(e);
   endtask

   task automatic s_memadr();
      ctl_t e = blank(4'd2);
      e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
      push_n(e);
   endtask

   task automatic s_memwrite(input logic rd);
      ctl_t e = blank(4'd5);
      e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1;
      push(1'b0, rd, noise, e);
      noise = ~noise;
   endtask

   // One whole instruction: fw fetch wait cycles, mw data-memory wait cycles
   task automatic instr(input logic [6:0] o, input logic f, input logic z, input int fw, input int mw);
      ctl_t e;
      m_op = o; m_f3 = f;
      s_fetch(fw);
      e = blank(4'd1); e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
      push_n(e);
      case (o)
         LW: begin
            s_memadr();
            for (int i = 0; i <= mw; i++) begin
               e = blank(4'd3); e.mem_req = 1'b1; e.adr_src = 1'b1;
               push(1'b0, (i == mw), noise, e);
               noise = ~noise;
            end
            e = blank(4'd4); e.result_src = 2'b01; e.reg_write = 1'b1;
            push_n(e);
            m_cnt++;
         end
         SW: begin
            s_memadr();
            for (int i = 0; i <= mw; i++) s_memwrite(i == mw);
            m_cnt++;
         end
         RT, IT: begin
            e = blank((o == RT) ? 4'd6 : 4'd7);
            e.alu_src_a = 2'b10; e.alu_op = 2'b10;
            e.alu_src_b = (o == RT) ? 2'b00 : 2'b01;
            push_n(e);
            s_aluwb();
            m_cnt++;
         end
         BR: begin
            e = blank(4'd9); e.alu_src_a = 2'b10; e.alu_op = 2'b01;
            e.pc_write = z ^ f;
            push(1'b0, noise, z, e);
            noise = ~noise;
            m_cnt++;
         end
         JL: begin
            e = blank(4'd10); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
            push_n(e);
            s_aluwb();
            m_cnt++;
         end
         default: begin
            m_ill = 1'b1;
            repeat (20) push_n(blank(4'd11));
         end
      endcase
   endtask

   task automatic build();
      int n;
      do_reset(2);
      n = q.size(); instr(LW, 1'b0, 1'b0, 0, 0); chk("lw_cycles", q.size() - n, 5);
      n = q.size(); instr(SW, 1'b0, 1'b0, 0, 2); chk("sw_wait_cycles", q.size() - n, 6);
      n = q.size(); instr(RT, 1'b0, 1'b0, 0, 0); chk("rtype_cycles", q.size() - n, 4);
      n = q.size(); instr(IT, 1'b0, 1'b1, 0, 0); chk("itype_cycles", q.size() - n, 4);
      n = q.size(); instr(BR, 1'b0, 1'b1, 0, 0); chk("beq_cycles", q.size() - n, 3);
      instr(BR, 1'b0, 1'b0, 0, 0);
      instr(BR, 1'b1, 1'b0, 0, 0);
      instr(BR, 1'b1, 1'b1, 1, 0);
      n = q.size(); instr(JL, 1'b0, 1'b0, 0, 0); chk("jal_cycles", q.size() - n, 4);
      n = q.size(); instr(LW, 1'b0, 1'b0, 2, 1); chk("lw_wait_cycles", q.size() - n, 8);
      chk("model_retired", m_cnt, 10);
      instr(BAD, 1'b0, 1'b0, 0, 0);
      do_reset(2);
      instr(RT, 1'b0, 1'b0, 0, 0);
      // sw aborted by reset while still waiting on memory
      m_op = SW; m_f3 = 1'b0;
      s_fetch(0);
      begin
         ctl_t e = blank(4'd1);
         e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
         push_n(e);
      end
      s_memadr();
      s_memwrite(1'b0);
      s_memwrite(1'b0);
      do_reset(2);
      for (int i = 0; i < 16; i++) instr((i % 2) ? IT : RT, 1'b0, 1'b0, i % 3, 0);
      chk("model_wrap_total", m_cnt, 16);
   endtask

   always @(negedge clk) begin
      #2;
      if (cur_v) begin
         chk("ctl32", {13'b0, a32}, {13'b0, cur.e});
         chk("instret32", b32.instret, cur.cnt);
         chk("ctl4", {13'b0, a4}, {13'b0, cur.e});
         chk("instret4", {28'b0, b4.instret}, {28'b0, cur.cnt[3:0]});
      end
   end

   initial begin
      build();
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         reset = q[i].rst; op = q[i].op; f3 = q[i].f3; zr = q[i].zr; rdy = q[i].rdy;
         cur = q[i]; cyc_i = i; cur_v = 1'b1;
      end
      @(negedge clk);
      cur_v = 1'b0; rdy = 1'b0; zr = 1'b0;
      #2;
      chk("final_state", {28'b0, b32.state_dbg}, 32'd0);
      chk("final_instret32", b32.instret, 32'd16);
      chk("final_instret4_wrapped", {28'b0, b4.instret}, 32'd0);
      chk("final_illegal", {31'b0, b32.illegal}, 32'd0);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
Main control FSM for the multicycle RISC-V core. It sequences the shared datapath (PC, instruction register, unified memory port, register file, single ALU) through fetch, decode, execute, memory and writeback steps for lw, sw, R-type, I-type ALU, beq/bne and jal. It sits inside riscv_multicycle_Top beside the ALU decoder and the immediate extender. It also handshakes with a wait-stated memory, counts retired instructions and traps on illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_W, 7, opcode field width (fixed at 7; exposed for lint only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from the instruction register
funct3_0  in  1  instr[12]; selects bne (1) or beq (0)
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
adr_src  out  1  0 = PC, 1 = Result
mem_write  out  1  store strobe
ir_write  out  1  load the instruction register (and OldPC)
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = const 4
alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
reg_write  out  1  register file write enable
pc_write  out  1  PC enable
illegal  out  1  sticky illegal-opcode flag
instret  out  CNT_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11. Codes 12-15 go to FETCH next cycle with all outputs 0.
- Reset: state=FETCH, instret=0, illegal=0. While reset is high, every control output is forced to 0.
- Outputs not listed for a state are 0. Outputs are combinational from the state, plus the mem_ready/zero terms given below.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write equal mem_ready. Stays in FETCH while !mem_ready; when mem_ready, goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; anything else -> TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, result_src=00, mem_write=1, held until mem_ready. Then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: same as EXECR but alu_src_b=01, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = zero XOR funct3_0. Then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then ALUWB.
- TRAP: all control outputs 0. illegal is set on entry and held until reset. TRAP is absorbing.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^CNT_W. A jal retires via ALUWB and is counted once.
- Memory wait: mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE, and ignored elsewhere. mem_req stays high, with address and strobe controls stable, until the cycle mem_ready=1.
- Cycle counts with zero wait states:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type / I-type: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - Each memory wait cycle adds 1.
- Reset mid-operation: asynchronous return to FETCH. A pending mem_req drops immediately, with no partial write strobe after reset rises. instret is cleared.

Test Plan:
- Reset, then lw (opcode 0000011) with mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB with result_src=01; instret=1.
- sw (0100011) with mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 and adr_src=1 held 3 cycles; returns to FETCH; no reg_write pulse.
- beq (1100011, funct3_0=0): zero=1 gives pc_write=1 in BRANCH; zero=0 gives pc_write=0. bne (funct3_0=1) with zero=0 gives pc_write=1. Each retires one instruction.
- jal (1101111) -> states 0,1,10,8,0; pc_write=1 in JAL; reg_write=1 in ALUWB; instret increments by exactly 1.
- Opcode 0000000 -> TRAP after DECODE; illegal=1 and all controls 0 for 20 cycles; reset clears illegal and returns to FETCH.
- Assert reset during MEMWRITE while mem_ready=0 -> mem_write and mem_req fall in the same cycle; state=FETCH and instret=0 after release; then 2^CNT_W wrap is checked with CNT_W=4 over 16 R-type instructions -> instret=0.
